shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 ctrl_start  input  1  request to begin a shift; accepted only when ready=1.
REQ-005 ctrl_op  input  1  shift type: 0 = logical left (SLL), 1 = arithmetic right (SRA).
REQ-006 data_operand  input  32  value to shift; sampled at accept.
REQ-007 ctrl_shiftamt  input  5  shift distance, 0-31; sampled at accept.
REQ-008 ready  output  1  high when idle and able to accept ctrl_start.
REQ-009 data_result  output  32  shifted value; valid while data_resultRDY=1.
REQ-010 data_resultRDY  output  1  result-valid flag; held until acknowledged.
REQ-011 result_ack  input  1  consumer acknowledge; meaningful only while data_resultRDY=1.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE; ready = (state==IDLE) and data_resultRDY = (state==DONE).
REQ-013 Accept: at an edge with state==IDLE and ctrl_start=1, the block SHALL latch data_operand into acc, ctrl_shiftamt into amt and ctrl_op into op, set stage counter cnt=4, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL apply the fixed stage of 2^cnt bits (16, 8, 4, 2, 1) to acc only if amt[cnt]=1; otherwise acc is held.
REQ-015 SLL stage: shift acc left by 2^cnt and zero-fill the low bits. SRA stage: shift right by 2^cnt and fill the vacated high bits with acc[31] (sign extension).
REQ-016 In SHIFT with cnt==0: after applying the stage, go to DONE; otherwise decrement cnt.
REQ-017 Latency SHALL be fixed: accept at edge E0, stages at E1..E5, data_resultRDY=1 in the cycle after E5, independent of shift amount (amount 0 included).
REQ-018 In DONE, data_result SHALL equal acc and stay stable; an edge with result_ack=1 SHALL return to IDLE. Without result_ack, DONE is held indefinitely (backpressure).
REQ-019 data_result SHALL show acc in every state. It is only guaranteed meaningful in DONE.
REQ-020 ctrl_start while not in IDLE SHALL be ignored: no latch and no state change, including ctrl_start and result_ack in the same DONE cycle.
REQ-021 result_ack outside DONE SHALL be ignored.
REQ-022 Input changes after accept SHALL NOT affect the operation in flight.
REQ-023 Back-to-back throughput SHALL be one operation per 7 cycles minimum (accept, 5 shifts, 1 DONE cycle with immediate ack).

Reset
REQ-024 With reset=1 at an edge, the block SHALL go to IDLE and clear acc, amt, op and cnt to 0, so data_result=0, data_resultRDY=0 and ready=1 after that edge.
REQ-025 Reset SHALL override all other inputs, including ctrl_start and result_ack in the same edge.
REQ-026 Reset in SHIFT or DONE SHALL abort the operation with no result produced. Normal operation resumes at the first edge with reset=0.

Verification
REQ-027 Sign fill: SRA, data_operand=0x80000000, amt=8 -> data_resultRDY high 5 edges after accept, data_result=0xFF800000.
REQ-028 Full left shift: SLL, 0x00000001, amt=31 -> 0x80000000. SRA, 0x7FFFFFFF, amt=31 -> 0x00000000. SRA, 0xFFFFFFFF, amt=31 -> 0xFFFFFFFF.
REQ-029 Zero amount: SLL, 0x12345678, amt=0 -> 0x12345678, still after exactly 5 SHIFT cycles.
REQ-030 Backpressure and busy: hold result_ack=0 for 10 cycles -> data_result and data_resultRDY stable throughout. Assert ctrl_start with new operands during SHIFT and DONE -> ignored. Ack -> ready=1 on the next cycle.
REQ-031 Mid-operation reset: reset asserted at the 3rd SHIFT edge -> ready=1, data_result=0, data_resultRDY=0. A following SLL 0x0000000F, amt=4 -> 0x000000F0.
REQ-032 Random regression: at least 1000 random operand/amount/op triples, checked against a reference model of SLL and SRA, with random ack delays of 0-5 cycles.

Source files
------------

// File: rtl/shift_sequencer.sv
// Purpose: 32-bit SLL/SRA barrel shift done as five fixed stages (16,8,4,2,1), one stage per clock.
// Latency: accept edge E0, stages E1..E5, data_resultRDY high in the cycle after E5, for any amount.
// Backpressure: result held in DONE until result_ack; ctrl_start is ignored unless ready=1.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic        ctrl_op,
  input  logic [31:0] data_operand,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic        result_ack,
  output logic        ready,
  output logic [31:0] data_result,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  amt;
  logic        op;
  logic [2:0]  cnt;
  logic [31:0] stage_out;
  logic        stage_en;

  // acc is visible in every state; it only carries a finished result in DONE.
  assign data_result = acc;

  // Stage selected by cnt is applied only when the matching amount bit is set.
  assign stage_en = amt[cnt];

  // One fixed-distance stage: 2^cnt bits, zero fill for SLL, sign fill for SRA.
  always_comb begin
    stage_out = acc;
    case (cnt)
      3'd4: stage_out = op ? {{16{acc[31]}}, acc[31:16]} : {acc[15:0], 16'b0};
      3'd3: stage_out = op ? {{8{acc[31]}},  acc[31:8]}  : {acc[23:0], 8'b0};
      3'd2: stage_out = op ? {{4{acc[31]}},  acc[31:4]}  : {acc[27:0], 4'b0};
      3'd1: stage_out = op ? {{2{acc[31]}},  acc[31:2]}  : {acc[29:0], 2'b0};
      3'd0: stage_out = op ? {acc[31],       acc[31:1]}  : {acc[30:0], 1'b0};
      default: stage_out = acc;
    endcase
  end

  // Sequencer: state, operand capture, stage stepping and registered handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      acc            <= 32'd0;
      amt            <= 5'd0;
      op             <= 1'b0;
      cnt            <= 3'd0;
      ready          <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            acc   <= data_operand;
            amt   <= ctrl_shiftamt;
            op    <= ctrl_op;
            cnt   <= 3'd4;
            state <= SHIFT;
            ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (stage_en) begin
            acc <= stage_out;
          end
          if (cnt == 3'd0) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          // A simultaneous ctrl_start is dropped; only the ack matters here.
          if (result_ack) begin
            state          <= IDLE;
            ready          <= 1'b1;
            data_resultRDY <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          ready          <= 1'b1;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random checks of the staged SLL/SRA sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every wait on the DUT is bounded; a timeout shows up as a latency mismatch.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_op;
  logic [31:0] data_operand;
  logic [4:0]  ctrl_shiftamt;
  logic        result_ack;
  logic        ready;
  logic [31:0] data_result;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .data_operand   (data_operand),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .result_ack     (result_ack),
    .ready          (ready),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: whole-distance shift, independent of the staged decomposition.
  function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] v, input logic [4:0] a);
    logic signed [31:0] sv;
    sv = v;
    if (o) ref_shift = 32'(sv >>> a);
    else   ref_shift = v << a;
  endfunction

  // Present a request for one edge (the accept edge E0), then drop ctrl_start.
  task automatic start_op(input logic o, input logic [31:0] v, input logic [4:0] a);
    ctrl_start    = 1'b1;
    ctrl_op       = o;
    data_operand  = v;
    ctrl_shiftamt = a;
    @(posedge clock); #1;
    ctrl_start    = 1'b0;
  endtask

  // Count edges after the current point until data_resultRDY, bounded at 20.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (data_resultRDY !== 1'b1 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  // One-edge acknowledge.
  task automatic ack_once;
    result_ack = 1'b1;
    @(posedge clock); #1;
    result_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ctrl_start = 1'b1; result_ack = 1'b1;
    ctrl_op = 1'b1; data_operand = 32'hDEADBEEF; ctrl_shiftamt = 5'd7;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++;
    if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    n_checks++;
    if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", data_result); end
    reset = 1'b0; ctrl_start = 1'b0; result_ack = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: ready got %b expected 1", ready); end
  endtask

  task automatic test_sign_fill;
    int cyc;
    start_op(1'b1, 32'h80000000, 5'd8);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL sign_fill_latency: got %0d expected 5", cyc); end
    n_checks++;
    if (data_result !== 32'hFF800000) begin n_fail++; $display("FAIL sign_fill: got %h expected ff800000", data_result); end
    ack_once();
  endtask

  task automatic test_full_shift;
    int cyc;
    logic        ops  [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] vals [3] = '{32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps [3] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], vals[i], 5'd31);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 5 || data_result !== exps[i]) begin
        n_fail++;
        $display("FAIL full_shift[%0d]: got %h after %0d edges expected %h after 5", i, data_result, cyc, exps[i]);
      end
      ack_once();
    end
  endtask

  // Zero amount, with stray acks during SHIFT that must be ignored.
  task automatic test_zero_amt;
    int cyc;
    start_op(1'b0, 32'h12345678, 5'd0);
    result_ack = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    result_ack = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL ack_in_shift: ready %b rdy %b expected 0 0", ready, data_resultRDY);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc + 3 !== 5) begin n_fail++; $display("FAIL zero_amt_latency: got %0d expected 5", cyc + 3); end
    n_checks++;
    if (data_result !== 32'h12345678) begin n_fail++; $display("FAIL zero_amt: got %h expected 12345678", data_result); end
    ack_once();
  endtask

  task automatic test_backpressure;
    int cyc;
    start_op(1'b0, 32'hA5A50001, 5'd3);
    // New request held high through SHIFT and DONE.
    ctrl_start = 1'b1; ctrl_op = 1'b1; data_operand = 32'hFFFFFFFF; ctrl_shiftamt = 5'd1;
    wait_done(cyc);
    n_checks++;
    if (cyc !== 5 || data_result !== 32'h2D280008) begin
      n_fail++; $display("FAIL busy_ignore: got %h after %0d edges expected 2d280008 after 5", data_result, cyc);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (data_resultRDY !== 1'b1 || data_result !== 32'h2D280008) begin
        n_fail++; $display("FAIL hold[%0d]: rdy %b result %h expected 1 2d280008", i, data_resultRDY, data_result);
      end
    end
    // Ack and start together in DONE: ack returns to IDLE, start is not latched.
    ack_once();
    ctrl_start = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL ack_release: ready %b rdy %b expected 1 0", ready, data_resultRDY);
    end
    n_checks++;
    if (data_result !== 32'h2D280008) begin n_fail++; $display("FAIL start_in_done: got %h expected 2d280008", data_result); end
    @(posedge clock); #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL still_idle: ready got %b expected 1", ready); end
  endtask

  task automatic test_mid_reset;
    int cyc;
    start_op(1'b0, 32'h12345678, 5'd5);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || data_resultRDY !== 1'b0 || data_result !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: ready %b rdy %b result %h expected 1 0 00000000", ready, data_resultRDY, data_result);
    end
    start_op(1'b0, 32'h0000000F, 5'd4);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 5 || data_result !== 32'h000000F0) begin
      n_fail++; $display("FAIL after_reset_op: got %h after %0d edges expected 000000f0 after 5", data_result, cyc);
    end
    ack_once();
  endtask

  // Ack in the first DONE cycle, next request on the following edge: 7-edge period.
  task automatic test_back_to_back;
    int cyc;
    start_op(1'b1, 32'hF0000000, 5'd4);
    wait_done(cyc);
    n_checks++;
    if (data_result !== 32'hFF000000) begin n_fail++; $display("FAIL b2b_first: got %h expected ff000000", data_result); end
    ack_once();
    start_op(1'b0, 32'h00000003, 5'd30);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready got %b expected 0", ready); end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 5 || data_result !== 32'hC0000000) begin
      n_fail++; $display("FAIL b2b_second: got %h after %0d edges expected c0000000 after 5", data_result, cyc);
    end
    ack_once();
  endtask

  task automatic test_random;
    int cyc;
    logic        o;
    logic [31:0] v;
    logic [4:0]  a;
    logic [31:0] exp;
    for (int i = 0; i < 1000; i++) begin
      o = 1'($urandom_range(0, 1));
      v = $urandom;
      a = 5'($urandom_range(0, 31));
      exp = ref_shift(o, v, a);
      start_op(o, v, a);
      wait_done(cyc);
      repeat ($urandom_range(0, 5)) begin
        @(posedge clock); #1;
      end
      n_checks++;
      if (cyc !== 5 || data_resultRDY !== 1'b1 || data_result !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] op %b v %h a %0d: got %h after %0d edges expected %h after 5", i, o, v, a, data_result, cyc, exp);
      end
      ack_once();
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_start = 1'b0; ctrl_op = 1'b0;
    data_operand = 32'h0; ctrl_shiftamt = 5'd0; result_ack = 1'b0;
    test_reset();
    test_sign_fill();
    test_full_shift();
    test_zero_amt();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
